// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU class encodings, NZCV bit positions and the
// packed flags type used by the status register and the condition evaluator.
package cpu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_LOGIC = 2'b10
  } alu_class_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  localparam flags_t FLAGS_CLEAR = 4'b0000;

endpackage

// File: rtl/status_flags_reg_if.sv
// Bundle between the execute stage and the NZCV status register: ALU
// operands/result/carries, commit controls, and the registered flag/stack view.
interface status_flags_reg_if #(
  parameter int WIDTH = 32
);

  logic [1:0]       alu_class;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] alu_result;
  logic             adder_carry;
  logic             shifter_carry;
  logic             update_en;
  logic             msr_we;
  logic [3:0]       msr_data;
  logic             exc_entry;
  logic             exc_return;

  logic             negative_flag;
  logic             zero_flag;
  logic             carry_flag;
  logic             overflow_flag;
  logic [3:0]       saved_flags;
  logic             stack_empty;
  logic             stack_full;
  logic             stack_overflow;
  logic             stack_underflow;

  // Execute stage side: drives requests, observes flags
  modport master (
    output alu_class, operand_a, operand_b, alu_result, adder_carry,
           shifter_carry, update_en, msr_we, msr_data, exc_entry, exc_return,
    input  negative_flag, zero_flag, carry_flag, overflow_flag, saved_flags,
           stack_empty, stack_full, stack_overflow, stack_underflow
  );

  // Status register side
  modport slave (
    input  alu_class, operand_a, operand_b, alu_result, adder_carry,
           shifter_carry, update_en, msr_we, msr_data, exc_entry, exc_return,
    output negative_flag, zero_flag, carry_flag, overflow_flag, saved_flags,
           stack_empty, stack_full, stack_overflow, stack_underflow
  );

endinterface

// File: rtl/flag_gen.sv
// Combinational next-NZCV generator. Overflow is derived from sign bits only;
// for SUB operand_b is the un-inverted operand, so the sign test is "differ".
module flag_gen
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       alu_class,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             adder_carry,
  input  logic             shifter_carry,
  input  logic             cur_v,
  output flags_t           next_flags
);

  localparam int M = WIDTH - 1;

  logic a_msb;
  logic b_msb;
  logic r_msb;

  assign a_msb = operand_a[M];
  assign b_msb = operand_b[M];
  assign r_msb = alu_result[M];

  // Only the operand sign bits matter for overflow
  logic unused_operand_bits;
  assign unused_operand_bits = ^{operand_a[M-1:0], operand_b[M-1:0]};

  // Next flags by ALU class; reserved class behaves as LOGIC
  always_comb begin
    next_flags         = FLAGS_CLEAR;
    next_flags[FLAG_N] = r_msb;
    next_flags[FLAG_Z] = (alu_result == '0);
    case (alu_class)
      ALU_ADD: begin
        next_flags[FLAG_C] = adder_carry;
        next_flags[FLAG_V] = (a_msb == b_msb) & (r_msb != a_msb);
      end
      ALU_SUB: begin
        next_flags[FLAG_C] = adder_carry;
        next_flags[FLAG_V] = (a_msb != b_msb) & (r_msb != a_msb);
      end
      default: begin
        next_flags[FLAG_C] = shifter_carry;
        next_flags[FLAG_V] = cur_v;
      end
    endcase
  end

endmodule

// File: rtl/status_flags_reg.sv
// Architectural NZCV register with a small save/restore LIFO for exception
// nesting. One action per cycle: entry > return > msr > update; losers dropped.
module status_flags_reg
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  status_flags_reg_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flags_t           flags;
  flags_t           next_flags;
  flags_t           stack_mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic             ovf_sticky;
  logic             unf_sticky;
  logic             empty;
  logic             full;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;

  flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .alu_class     (bus.alu_class),
    .operand_a     (bus.operand_a),
    .operand_b     (bus.operand_b),
    .alu_result    (bus.alu_result),
    .adder_carry   (bus.adder_carry),
    .shifter_carry (bus.shifter_carry),
    .cur_v         (flags[FLAG_V]),
    .next_flags    (next_flags)
  );

  assign empty    = (ptr == '0);
  assign full     = (ptr == PTR_W'(DEPTH));
  // Index casts are safe: push is blocked when full, pop when empty
  assign push_idx = IDX_W'(ptr);
  assign top_idx  = IDX_W'(ptr - 1'b1);

  // Prioritised single action per cycle on flags, stack and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags      <= FLAGS_CLEAR;
      ptr        <= '0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_mem[i] <= FLAGS_CLEAR;
      end
    end else if (bus.exc_entry) begin
      if (full) begin
        ovf_sticky <= 1'b1;
      end else begin
        stack_mem[push_idx] <= flags;
        ptr                 <= ptr + 1'b1;
      end
    end else if (bus.exc_return) begin
      if (empty) begin
        unf_sticky <= 1'b1;
      end else begin
        flags <= stack_mem[top_idx];
        ptr   <= ptr - 1'b1;
      end
    end else if (bus.msr_we) begin
      flags <= bus.msr_data;
    end else if (bus.update_en) begin
      flags <= next_flags;
    end
  end

  assign bus.negative_flag   = flags[FLAG_N];
  assign bus.zero_flag       = flags[FLAG_Z];
  assign bus.carry_flag      = flags[FLAG_C];
  assign bus.overflow_flag   = flags[FLAG_V];
  assign bus.saved_flags     = empty ? FLAGS_CLEAR : stack_mem[top_idx];
  assign bus.stack_empty     = empty;
  assign bus.stack_full      = full;
  assign bus.stack_overflow  = ovf_sticky;
  assign bus.stack_underflow = unf_sticky;

endmodule
